// File: rtl/program_loader.sv
// program_loader
//
// Front end of the instruction decoder. Takes a valid/ready stream of
// instruction words and writes them into the decoder's instruction memory.
// It then reads every word back and compares the XOR of the read-back words
// with the XOR of the words it wrote. When the two agree it raises
// is_instruction_stored, which lets the decoder start executing.
//
// Ports
//   clock                  single clock; all state changes on the rising edge
//   reset_VM_n             asynchronous, active-low reset
//   start                  one-cycle pulse that begins a load (only seen in IDLE)
//   word_count             number of words N; legal range is 1..DEPTH
//   in_valid / in_data     incoming instruction stream
//   in_ready               the loader accepts a word this cycle (LOAD state only)
//   address_VM             memory address (registered)
//   datain_VM              memory write data (registered)
//   mode_VM                1 = write, 0 = read (registered)
//   dataout_VM             memory read data; valid the cycle after the address
//   is_instruction_stored  program loaded and verified
//   busy                   high in every state except IDLE
//   load_error             illegal count or failed verify; sticky until the
//                          next accepted start
//   checksum               XOR of all words accepted in the current/last load

module program_loader #(
  parameter int DEPTH  = 18,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_VM_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address_VM,
  output logic [DATA_W-1:0] datain_VM,
  output logic              mode_VM,
  input  logic [DATA_W-1:0] dataout_VM,
  output logic              is_instruction_stored,
  output logic              busy,
  output logic              load_error,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    VRD,
    VCHK,
    COMPARE
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE_W   = ADDR_W'(1);

  state_t            state, state_next;

  // n_last holds N-1, so both pointers stop at the last index and never wrap.
  logic [ADDR_W-1:0] n_last, n_last_next;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_next;
  logic [DATA_W-1:0] acc, acc_next;

  logic [ADDR_W-1:0] address_next;
  logic [DATA_W-1:0] datain_next;
  logic              mode_next;
  logic              stored_next;
  logic              error_next;
  logic [DATA_W-1:0] checksum_next;

  logic              count_legal;

  assign in_ready    = (state == LOAD);
  assign busy        = (state != IDLE);
  assign count_legal = (word_count != '0) && (word_count <= DEPTH_W);

  always_ff @(posedge clock or negedge reset_VM_n) begin
    if (!reset_VM_n) begin
      state                 <= IDLE;
      n_last                <= '0;
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      acc                   <= '0;
      address_VM            <= '0;
      datain_VM             <= '0;
      mode_VM               <= 1'b0;
      is_instruction_stored <= 1'b0;
      load_error            <= 1'b0;
      checksum              <= '0;
    end else begin
      state                 <= state_next;
      n_last                <= n_last_next;
      wr_ptr                <= wr_ptr_next;
      rd_ptr                <= rd_ptr_next;
      acc                   <= acc_next;
      address_VM            <= address_next;
      datain_VM             <= datain_next;
      mode_VM               <= mode_next;
      is_instruction_stored <= stored_next;
      load_error            <= error_next;
      checksum              <= checksum_next;
    end
  end

  // mode_next defaults to 0, so a write strobe lasts exactly one cycle per
  // accepted word. Every other register holds its value unless a state
  // updates it.
  always_comb begin
    state_next    = state;
    n_last_next   = n_last;
    wr_ptr_next   = wr_ptr;
    rd_ptr_next   = rd_ptr;
    acc_next      = acc;
    address_next  = address_VM;
    datain_next   = datain_VM;
    mode_next     = 1'b0;
    stored_next   = is_instruction_stored;
    error_next    = load_error;
    checksum_next = checksum;

    case (state)
      IDLE: begin
        if (start) begin
          if (count_legal) begin
            n_last_next   = word_count - ONE_W;
            checksum_next = '0;
            acc_next      = '0;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            error_next    = 1'b0;
            stored_next   = 1'b0;
            state_next    = LOAD;
          end else begin
            error_next = 1'b1;
          end
        end
      end

      // in_ready is high throughout LOAD, so in_valid alone means an accept.
      LOAD: begin
        if (in_valid) begin
          mode_next     = 1'b1;
          address_next  = wr_ptr;
          datain_next   = in_data;
          checksum_next = checksum ^ in_data;
          if (wr_ptr == n_last) begin
            state_next = FLUSH;
          end else begin
            wr_ptr_next = wr_ptr + ONE_W;
          end
        end
      end

      // The last write is on the bus during FLUSH. Point the address at word 0
      // so the first read is already presented in VRD.
      FLUSH: begin
        address_next = '0;
        state_next   = VRD;
      end

      VRD: begin
        state_next = VCHK;
      end

      VCHK: begin
        acc_next = acc ^ dataout_VM;
        if (rd_ptr == n_last) begin
          state_next = COMPARE;
        end else begin
          rd_ptr_next  = rd_ptr + ONE_W;
          address_next = rd_ptr + ONE_W;
          state_next   = VRD;
        end
      end

      COMPARE: begin
        if (acc == checksum) begin
          stored_next = 1'b1;
        end else begin
          error_next = 1'b1;
        end
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//
// Directed bench for program_loader. A behavioural instruction memory sits
// on the address_VM/datain_VM/mode_VM/dataout_VM port. It logs every write
// and can flip bit 0 of the word read back from address 1.

module tb_program_loader;

  logic        clock;
  logic        reset_VM_n;
  logic        start;
  logic [4:0]  word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [4:0]  address_VM;
  logic [31:0] datain_VM;
  logic        mode_VM;
  logic [31:0] dataout_VM;
  logic        is_instruction_stored;
  logic        busy;
  logic        load_error;
  logic [31:0] checksum;

  int tests    = 0;
  int failures = 0;
  int edge_no  = 0;
  logic last_busy;

  logic [31:0] mem [0:31];
  logic [4:0]  wr_addr_log [0:63];
  logic [31:0] wr_data_log [0:63];
  int          wr_cnt  = 0;
  logic        corrupt = 1'b0;

  logic [31:0] prog [0:17];

  program_loader #(.DEPTH(18), .ADDR_W(5), .DATA_W(32)) dut (
    .clock                 (clock),
    .reset_VM_n            (reset_VM_n),
    .start                 (start),
    .word_count            (word_count),
    .in_valid              (in_valid),
    .in_data               (in_data),
    .in_ready              (in_ready),
    .address_VM            (address_VM),
    .datain_VM             (datain_VM),
    .mode_VM               (mode_VM),
    .dataout_VM            (dataout_VM),
    .is_instruction_stored (is_instruction_stored),
    .busy                  (busy),
    .load_error            (load_error),
    .checksum              (checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered-read memory; read data appears the cycle after the address.
  always @(posedge clock) begin
    if (mode_VM) begin
      mem[address_VM]          <= datain_VM;
      wr_addr_log[wr_cnt[5:0]] <= address_VM;
      wr_data_log[wr_cnt[5:0]] <= datain_VM;
      wr_cnt                   <= wr_cnt + 1;
    end
    dataout_VM <= (corrupt && address_VM == 5'd1) ? (mem[address_VM] ^ 32'h1)
                                                   : mem[address_VM];
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
    edge_no++;
  endtask

  task automatic applyStimulus(input logic s, input logic [4:0] wc,
                               input logic v, input logic [31:0] d);
    start      = s;
    word_count = wc;
    in_valid   = v;
    in_data    = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues start on edge 0, streams n words with an optional gap of gap_len
  // idle cycles before word gap_idx, then waits (bounded) for completion.
  task automatic runLoad(input int n, input int gap_idx, input int gap_len,
                         output int done_edge);
    applyStimulus(1'b1, n[4:0], 1'b0, 32'h0);
    tick();
    edge_no = 0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_idx) begin
        applyStimulus(1'b0, 5'd0, 1'b0, 32'h0);
        repeat (gap_len) tick();
        checkOutput("gap_no_write_mode", {31'b0, mode_VM}, 32'h0);
      end
      applyStimulus(1'b0, 5'd0, 1'b1, prog[i]);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0);
    last_busy = busy;
    while (!is_instruction_stored && !load_error && edge_no < 3 * n + 30) begin
      last_busy = busy;
      tick();
    end
    done_edge = edge_no;
  endtask

  initial begin
    int e;
    int base;
    logic [31:0] exp_sum;

    // Reset state
    reset_VM_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_address", {27'b0, address_VM}, 32'h0);
    checkOutput("reset_mode", {31'b0, mode_VM}, 32'h0);
    checkOutput("reset_stored", {31'b0, is_instruction_stored}, 32'h0);
    checkOutput("reset_error", {31'b0, load_error}, 32'h0);
    checkOutput("reset_checksum", checksum, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'h0);
    reset_VM_n = 1'b1;

    // N=3 basic load
    $display("[TB] N=3 load");
    prog[0] = 32'h20000001;
    prog[1] = 32'h90000000;
    prog[2] = 32'h00022022;
    base = wr_cnt;
    runLoad(3, -1, 0, e);
    checkOutput("n3_stored_edge", e, 32'd11);
    checkOutput("n3_stored", {31'b0, is_instruction_stored}, 32'h1);
    checkOutput("n3_error", {31'b0, load_error}, 32'h0);
    checkOutput("n3_checksum", checksum, 32'hB0022023);
    checkOutput("n3_write_cycles", wr_cnt - base, 32'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("n3_wr_addr%0d", i), {27'b0, wr_addr_log[(base + i) % 64]}, i);
      checkOutput($sformatf("n3_wr_data%0d", i), wr_data_log[(base + i) % 64], prog[i]);
    end

    // Full N=18 load
    $display("[TB] N=18 load");
    exp_sum = 32'h0;
    for (int i = 0; i < 18; i++) begin
      prog[i] = 32'hA5000000 ^ (i * 32'h00010203) ^ (i << 27);
      exp_sum = exp_sum ^ prog[i];
    end
    runLoad(18, -1, 0, e);
    checkOutput("n18_stored_edge", e, 32'd56);
    checkOutput("n18_stored", {31'b0, is_instruction_stored}, 32'h1);
    checkOutput("n18_checksum", checksum, exp_sum);
    checkOutput("n18_busy_before", {31'b0, last_busy}, 32'h1);
    checkOutput("n18_busy_after", {31'b0, busy}, 32'h0);
    for (int i = 0; i < 18; i++) begin
      checkOutput($sformatf("n18_mem%0d", i), mem[i], prog[i]);
    end

    // N=2 with a two-cycle in_valid gap
    $display("[TB] N=2 load with gap");
    prog[0] = 32'h0000_1111;
    prog[1] = 32'h2222_0000;
    base = wr_cnt;
    runLoad(2, 1, 2, e);
    checkOutput("gap_stored_edge", e, 32'd10);
    checkOutput("gap_write_cycles", wr_cnt - base, 32'd2);
    checkOutput("gap_wr_addr1", {27'b0, wr_addr_log[(base + 1) % 64]}, 32'd1);
    checkOutput("gap_checksum", checksum, 32'h2222_1111);

    // Illegal word counts
    $display("[TB] illegal counts");
    base = wr_cnt;
    applyStimulus(1'b1, 5'd0, 1'b1, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 32'hDEADBEEF);
    checkOutput("cnt0_error", {31'b0, load_error}, 32'h1);
    checkOutput("cnt0_busy", {31'b0, busy}, 32'h0);
    checkOutput("cnt0_in_ready", {31'b0, in_ready}, 32'h0);
    checkOutput("cnt0_stored_kept", {31'b0, is_instruction_stored}, 32'h1);
    repeat (3) tick();
    applyStimulus(1'b1, 5'd19, 1'b1, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 32'hDEADBEEF);
    checkOutput("cnt19_error", {31'b0, load_error}, 32'h1);
    checkOutput("cnt19_busy", {31'b0, busy}, 32'h0);
    checkOutput("cnt19_in_ready", {31'b0, in_ready}, 32'h0);
    repeat (3) tick();
    checkOutput("bad_cnt_no_write", wr_cnt - base, 32'd0);
    checkOutput("bad_cnt_mode", {31'b0, mode_VM}, 32'h0);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0);

    // Corrupted readback of address 1
    $display("[TB] corrupted readback");
    corrupt = 1'b1;
    prog[0] = 32'h20000001;
    prog[1] = 32'h90000000;
    prog[2] = 32'h00022022;
    runLoad(3, -1, 0, e);
    checkOutput("bad_verify_edge", e, 32'd11);
    checkOutput("bad_verify_error", {31'b0, load_error}, 32'h1);
    checkOutput("bad_verify_stored", {31'b0, is_instruction_stored}, 32'h0);
    checkOutput("bad_verify_busy", {31'b0, busy}, 32'h0);
    corrupt = 1'b0;

    // Reset in the middle of a load, then a fresh N=1 load
    $display("[TB] reset mid-load");
    for (int i = 0; i < 5; i++) prog[i] = 32'h0F0F0000 + i + 1;
    applyStimulus(1'b1, 5'd5, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 5'd0, 1'b1, prog[i]);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0);
    reset_VM_n = 1'b0;
    #1;
    checkOutput("midrst_address", {27'b0, address_VM}, 32'h0);
    checkOutput("midrst_datain", datain_VM, 32'h0);
    checkOutput("midrst_mode", {31'b0, mode_VM}, 32'h0);
    checkOutput("midrst_checksum", checksum, 32'h0);
    checkOutput("midrst_error", {31'b0, load_error}, 32'h0);
    checkOutput("midrst_busy", {31'b0, busy}, 32'h0);
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'h0);
    @(posedge clock);
    #1;
    reset_VM_n = 1'b1;
    prog[0] = 32'h13579BDF;
    runLoad(1, -1, 0, e);
    checkOutput("n1_stored_edge", e, 32'd5);
    checkOutput("n1_stored", {31'b0, is_instruction_stored}, 32'h1);
    checkOutput("n1_checksum", checksum, 32'h13579BDF);
    checkOutput("n1_error", {31'b0, load_error}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
